// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer
//   Issues instruction fetches to imem at the address supplied by program_counter.
//   Returned words go into a DEPTH-entry prefetch FIFO that feeds decode. The block
//   produces the stall that holds program_counter. At most one fetch is outstanding
//   at a time. A taken branch flushes the FIFO and discards any in-flight response.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   pc, branch_taken               fetch address and redirect from program_counter
//   stall                          hold program_counter (combinational)
//   imem_req/addr/ready            fetch request handshake
//   imem_rvalid/rdata              fetch response
//   instr_valid/instr/instr_pc     FIFO head toward decode
//   instr_ready                    decode pops the head
module instr_fetch_buffer #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  input  logic        branch_taken,
  output logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   rd_q, rd_d;
  logic [PW-1:0]   wr_q, wr_d;
  logic [31:0]     addr_q;
  logic [63:0]     data_q [DEPTH];

  logic accept;
  logic push;
  logic pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign imem_req    = (state_q == IDLE) && (count_q < CW'(DEPTH)) && !branch_taken && !rst;
  assign imem_addr   = pc;
  assign accept      = imem_req && imem_ready;
  // program_counter moves only on an accepted fetch or a redirect.
  assign stall       = rst || !(branch_taken || accept);

  // A request is only issued with a free slot, and count cannot grow while the
  // fetch is outstanding, so a push never meets a full FIFO.
  assign push        = (state_q == WAIT) && imem_rvalid && !branch_taken && !rst;
  assign instr_valid = (count_q != '0);
  assign pop         = instr_valid && instr_ready;

  assign instr       = instr_valid ? data_q[rd_q][31:0]  : '0;
  assign instr_pc    = instr_valid ? data_q[rd_q][63:32] : '0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid)       state_d = IDLE;
        else if (branch_taken) state_d = DRAIN;
      end
      DRAIN: begin
        if (imem_rvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (branch_taken) begin
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
    end else begin
      if (push) wr_d = ptr_inc(wr_q);
      if (pop)  rd_d = ptr_inc(rd_q);
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (!push && pop) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      if (accept) addr_q <= pc;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) data_q[wr_q] <= {addr_q, imem_rdata};
  end

  // A response with no fetch outstanding is ignored by the logic above.
  a_no_stray_rvalid: assert property (@(posedge clk) disable iff (rst)
    !((state_q == IDLE) && imem_rvalid));

endmodule

// File: tb/tb_instr_fetch_buffer.sv
module tb_instr_fetch_buffer;
  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        branch_taken;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  instr_fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .branch_taken(branch_taken),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: FIFO contents as a queue of {pc, word}, plus one optional
  // outstanding fetch that may be marked for discard.
  logic [63:0] q[$];
  bit          outst   = 1'b0;
  bit          discard = 1'b0;
  logic [31:0] m_addr  = '0;
  logic [31:0] pc_m    = '0;
  int          cd      = 0;      // imem response countdown, rvalid when 1
  int          next_delay = 1;
  bit          force_rv  = 1'b0;
  bit          dead_data = 1'b0;
  bit          armed     = 1'b0;
  logic [31:0] popped[$];

  logic        s_req, s_stall, s_valid;
  logic [31:0] s_addr, s_instr, s_ipc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input bit r, input bit br, input logic [31:0] tgt,
                      input bit rdy, input bit ir);
    bit e_req, acc, e_stall, e_valid, rvg, pushw;
    @(negedge clk);
    rst          = r;
    branch_taken = br;
    imem_ready   = rdy;
    instr_ready  = ir;
    pc           = pc_m;
    imem_rvalid  = force_rv || (cd == 1);
    imem_rdata   = dead_data ? 32'h0000_DEAD : $urandom;
    #1;
    e_req   = !r && !outst && (q.size() < DEPTH) && !br;
    acc     = e_req && rdy;
    e_stall = r || !(br || acc);
    e_valid = (q.size() != 0);
    if (armed) begin
      chk("imem_req", imem_req, e_req);
      chk("stall", stall, e_stall);
      chk("imem_addr", imem_addr, pc_m);
      chk("instr_valid", instr_valid, e_valid);
      if (e_valid) begin
        chk("instr", instr, q[0][31:0]);
        chk("instr_pc", instr_pc, q[0][63:32]);
      end
    end
    s_req = imem_req; s_stall = stall; s_valid = instr_valid;
    s_addr = imem_addr; s_instr = instr; s_ipc = instr_pc;
    rvg = outst && imem_rvalid;
    @(posedge clk);
    if (r) begin
      q.delete();
      outst = 1'b0; discard = 1'b0; pc_m = '0; cd = 0; armed = 1'b1;
    end else begin
      pushw = rvg && !discard && !br;
      if (br) q.delete();
      else begin
        if (e_valid && ir) begin
          popped.push_back(q[0][63:32]);
          void'(q.pop_front());
        end
        if (pushw) q.push_back({m_addr, imem_rdata});
      end
      if (rvg) outst = 1'b0;
      else if (acc) begin outst = 1'b1; discard = 1'b0; m_addr = pc_m; end
      else if (outst && br) discard = 1'b1;
      if (acc) cd = next_delay;
      else if (cd > 0) cd--;
      if (br) pc_m = tgt;
      else if (acc) pc_m = pc_m + 32'd4;
    end
  endtask

  initial begin
    rst = 1'b1; branch_taken = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0;
    imem_rdata = '0; instr_ready = 1'b0; pc = '0;

    // Reset state
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("rst_valid", s_valid, 0);
    chk("rst_req", s_req, 0);
    chk("rst_stall", s_stall, 1);
    chk("rst_instr", s_instr, 0);
    chk("rst_ipc", s_ipc, 0);

    // Streaming fetch, rvalid one cycle after accept
    popped.delete();
    next_delay = 1;
    repeat (8) step(0, 0, 0, 1, 1);
    chk("seq_cnt", popped.size() >= 3, 1);
    if (popped.size() >= 3) begin
      chk("seq_pc0", popped[0], 32'h0);
      chk("seq_pc1", popped[1], 32'h4);
      chk("seq_pc2", popped[2], 32'h8);
    end

    // FIFO fills with decode stalled
    step(1, 0, 0, 0, 0);
    repeat (6) step(0, 0, 0, 1, 0);
    chk("full_req", s_req, 0);
    chk("full_stall", s_stall, 1);
    chk("full_addr", s_addr, 32'h8);
    step(0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 0);
    chk("after_pop_req", s_req, 1);
    chk("after_pop_addr", s_addr, 32'h8);

    // imem back-pressure, then branch while waiting
    step(1, 0, 0, 0, 0);
    step(0, 1, 32'h10, 1, 1);
    next_delay = 3;
    repeat (3) begin
      step(0, 0, 0, 0, 1);
      chk("bp_addr", s_addr, 32'h10);
      chk("bp_stall", s_stall, 1);
      chk("bp_req", s_req, 1);
    end
    step(0, 0, 0, 1, 1);
    chk("bp_accept_stall", s_stall, 0);
    step(0, 1, 32'h100, 0, 1);
    chk("bp_pc_next", s_addr, 32'h14);
    step(0, 0, 0, 1, 1);
    chk("drain_req", s_req, 0);
    chk("drain_stall", s_stall, 1);
    dead_data = 1'b1;
    step(0, 0, 0, 1, 1);
    chk("drain_rv_req", s_req, 0);
    dead_data = 1'b0;
    step(0, 0, 0, 1, 1);
    chk("drain_empty", s_valid, 0);
    chk("redirect_req", s_req, 1);
    chk("redirect_addr", s_addr, 32'h100);
    next_delay = 1;

    // Branch in the same cycle as rvalid with an entry buffered
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 32'h200, 1, 1);
    step(0, 0, 0, 0, 0);
    chk("brrv_empty", s_valid, 0);
    chk("brrv_req", s_req, 1);
    chk("brrv_addr", s_addr, 32'h200);

    // Reset while waiting, stray response during reset
    step(1, 0, 0, 0, 0);
    next_delay = 3;
    step(0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 0);
    force_rv = 1'b1;
    step(1, 0, 0, 0, 0);
    force_rv = 1'b0;
    step(0, 0, 0, 0, 0);
    chk("rstw_valid", s_valid, 0);
    chk("rstw_req", s_req, 1);
    chk("rstw_addr", s_addr, 32'h0);

    // Randomized traffic
    step(1, 0, 0, 0, 0);
    repeat (3000) begin
      next_delay = $urandom_range(1, 3);
      step(($urandom_range(0, 99) < 1),
           ($urandom_range(0, 99) < 8),
           $urandom & 32'hFFFF_FFFC,
           ($urandom_range(0, 99) < 70),
           ($urandom_range(0, 99) < 60));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
